// File: rtl/cdc_sync_bus_if.sv
// Level-signal bundle for cdc_sync_bus: async inputs in, synchronised levels and edge pulses out.
interface cdc_sync_bus_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] signal_in;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  // Source side: drives the asynchronous levels and observes the results.
  modport master (
    output signal_in,
    input  signal_out,
    input  rise,
    input  fall,
    input  changed
  );

  // Synchroniser side.
  modport slave (
    input  signal_in,
    output signal_out,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/cdc_sync_bus.sv
// Multi-channel level synchroniser: per-bit flop chain, optional debounce filter,
// optional output register and rise/fall pulse generation. Bits are independent,
// so this must not be used to carry a coherent multi-bit value.
module cdc_sync_bus #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 0,
  parameter int unsigned      FANOUT        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  cdc_sync_bus_if.slave bus
);

  // A single flop cannot resolve metastability; refuse to build.
  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_bus: STAGES must be at least 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] out_lvl;
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain: pure shift, nothing between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], bus.signal_in};
    end
  end

  assign samp = sync_q[STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_no_filter
    assign stable = samp;
  end else begin : g_filter
    localparam int unsigned CNT_W =
      ($clog2(FILTER_CYCLES + 1) > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]            stable_q;

    // Debounce: accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= RESET_VAL;
        cnt_q    <= '0;
      end else begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (samp[i] == stable_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            stable_q[i] <= samp[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    assign stable = stable_q;
  end

  if (FANOUT != 0) begin : g_fanout
    logic [WIDTH-1:0] out_q;

    // Output register so signal_out can drive many loads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= RESET_VAL;
      end else begin
        out_q <= stable;
      end
    end

    assign out_lvl = out_q;
  end else begin : g_direct
    assign out_lvl = stable;
  end

  // Previous output level for edge detection; resets to RESET_VAL so release is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= out_lvl;
    end
  end

  assign bus.signal_out = out_lvl;
  assign bus.rise       = out_lvl & ~prev_q;
  assign bus.fall       = ~out_lvl & prev_q;
  assign bus.changed    = |(out_lvl ^ prev_q);

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Bench for cdc_sync_bus: four configurations, scoreboard of per-cycle expected outputs.
module tb_cdc_sync_bus;

  localparam int unsigned D_DEF = 0;  // defaults
  localparam int unsigned D_FLT = 1;  // FILTER_CYCLES=3
  localparam int unsigned D_RV  = 2;  // RESET_VAL=0xA5
  localparam int unsigned D_F0  = 3;  // FANOUT=0, STAGES=3

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_err;

  typedef struct {
    int unsigned at;
    int unsigned dut;
    logic [7:0]  out;
    logic [7:0]  rise;
    logic [7:0]  fall;
    string       tag;
  } exp_t;

  exp_t sb[$];

  cdc_sync_bus_if #(.WIDTH(8)) if_def ();
  cdc_sync_bus_if #(.WIDTH(8)) if_flt ();
  cdc_sync_bus_if #(.WIDTH(8)) if_rv  ();
  cdc_sync_bus_if #(.WIDTH(8)) if_f0  ();

  cdc_sync_bus #(.WIDTH(8)) u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_def)
  );

  cdc_sync_bus #(.WIDTH(8), .FILTER_CYCLES(3)) u_flt (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_flt)
  );

  cdc_sync_bus #(.WIDTH(8), .RESET_VAL(8'hA5)) u_rv (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rv)
  );

  cdc_sync_bus #(.WIDTH(8), .STAGES(3), .FANOUT(0)) u_f0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_f0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic get_obs(input int unsigned d, output logic [7:0] o, output logic [7:0] r,
                         output logic [7:0] f, output logic ch);
    case (d)
      D_DEF:   begin o = if_def.signal_out; r = if_def.rise; f = if_def.fall; ch = if_def.changed; end
      D_FLT:   begin o = if_flt.signal_out; r = if_flt.rise; f = if_flt.fall; ch = if_flt.changed; end
      D_RV:    begin o = if_rv.signal_out;  r = if_rv.rise;  f = if_rv.fall;  ch = if_rv.changed;  end
      default: begin o = if_f0.signal_out;  r = if_f0.rise;  f = if_f0.fall;  ch = if_f0.changed;  end
    endcase
  endtask

  task automatic push(input int unsigned d, input int unsigned at, input logic [7:0] o,
                      input logic [7:0] r, input logic [7:0] f, input string tag);
    exp_t e;
    e.at = at; e.dut = d; e.out = o; e.rise = r; e.fall = f; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: compare every entry due this cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          logic [7:0] o, r, f;
          logic ch;
          get_obs(sb[i].dut, o, r, f, ch);
          check_val({sb[i].tag, "_out"},  32'(o),  32'(sb[i].out));
          check_val({sb[i].tag, "_rise"}, 32'(r),  32'(sb[i].rise));
          check_val({sb[i].tag, "_fall"}, 32'(f),  32'(sb[i].fall));
          check_val({sb[i].tag, "_chg"},  32'(ch), 32'(|(sb[i].rise | sb[i].fall)));
          sb.delete(i);
        end else if (sb[i].at < cyc) begin
          n_err++;
          $display("FAIL %s: expectation for cycle %0d never checked", sb[i].tag, sb[i].at);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int unsigned c;
    logic [7:0] pat [6];
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    if_def.signal_in = 8'h00;
    if_flt.signal_in = 8'h00;
    if_rv.signal_in  = 8'hA5;
    if_f0.signal_in  = 8'h00;

    // Reset state.
    #22;
    check_val("rst_def_out", 32'(if_def.signal_out), 32'h00);
    check_val("rst_def_chg", 32'(if_def.changed),    32'h0);
    check_val("rst_rv_out",  32'(if_rv.signal_out),  32'hA5);
    check_val("rst_rv_rise", 32'(if_rv.rise),        32'h00);
    check_val("rst_rv_fall", 32'(if_rv.fall),        32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // Single-channel rise through default chain and through STAGES=3 without fanout reg.
    c = cyc;
    push(D_DEF, c + 2, 8'h00, 8'h00, 8'h00, "def_pre");
    push(D_DEF, c + 3, 8'h01, 8'h01, 8'h00, "def_rise");
    push(D_DEF, c + 4, 8'h01, 8'h00, 8'h00, "def_hold");
    push(D_F0,  c + 2, 8'h00, 8'h00, 8'h00, "f0_pre");
    push(D_F0,  c + 3, 8'h01, 8'h01, 8'h00, "f0_rise");
    push(D_F0,  c + 4, 8'h01, 8'h00, 8'h00, "f0_hold");
    if_def.signal_in = 8'h01;
    if_f0.signal_in  = 8'h01;
    wait_cyc(6);

    // Filter: 2-cycle pulse is swallowed.
    c = cyc;
    for (int j = 1; j <= 8; j++) push(D_FLT, c + j, 8'h00, 8'h00, 8'h00, "flt_short");
    if_flt.signal_in = 8'h01;
    wait_cyc(2);
    if_flt.signal_in = 8'h00;
    wait_cyc(8);

    // Filter: 3-cycle pulse passes, then the return to 0 also needs 3 samples.
    c = cyc;
    for (int j = 1; j <= 5; j++) push(D_FLT, c + j, 8'h00, 8'h00, 8'h00, "flt3_pre");
    push(D_FLT, c + 6,  8'h01, 8'h01, 8'h00, "flt3_rise");
    push(D_FLT, c + 7,  8'h01, 8'h00, 8'h00, "flt3_hi");
    push(D_FLT, c + 8,  8'h01, 8'h00, 8'h00, "flt3_hi2");
    push(D_FLT, c + 9,  8'h00, 8'h00, 8'h01, "flt3_fall");
    push(D_FLT, c + 10, 8'h00, 8'h00, 8'h00, "flt3_lo");
    if_flt.signal_in = 8'h01;
    wait_cyc(3);
    if_flt.signal_in = 8'h00;
    wait_cyc(12);

    // Filter: 1,1,0,1,1,1 restarts the count at the 0.
    pat[0] = 8'h01; pat[1] = 8'h01; pat[2] = 8'h00;
    pat[3] = 8'h01; pat[4] = 8'h01; pat[5] = 8'h01;
    c = cyc;
    for (int j = 1; j <= 8; j++) push(D_FLT, c + j, 8'h00, 8'h00, 8'h00, "flt_rst_pre");
    push(D_FLT, c + 9,  8'h01, 8'h01, 8'h00, "flt_rst_rise");
    push(D_FLT, c + 10, 8'h01, 8'h00, 8'h00, "flt_rst_hi");
    for (int j = 0; j < 6; j++) begin
      if_flt.signal_in = pat[j];
      wait_cyc(1);
    end
    wait_cyc(6);

    // Multi-channel: 0xF0 -> 0x0F in one cycle.
    if_def.signal_in = 8'hF0;
    wait_cyc(6);
    c = cyc;
    push(D_DEF, c + 2, 8'hF0, 8'h00, 8'h00, "mc_pre");
    push(D_DEF, c + 3, 8'h0F, 8'h0F, 8'hF0, "mc_edge");
    push(D_DEF, c + 4, 8'h0F, 8'h00, 8'h00, "mc_post");
    if_def.signal_in = 8'h0F;
    wait_cyc(6);

    // Move RESET_VAL instance away from 0xA5, then reset mid-transition back.
    c = cyc;
    push(D_RV, c + 3, 8'h5A, 8'h5A, 8'hA5, "rv_move");
    if_rv.signal_in = 8'h5A;
    wait_cyc(4);
    if_rv.signal_in = 8'hA5;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_rv_out",  32'(if_rv.signal_out),  32'hA5);
    check_val("arst_rv_chg",  32'(if_rv.changed),     32'h0);
    check_val("arst_def_out", 32'(if_def.signal_out), 32'h00);
    check_val("arst_flt_out", 32'(if_flt.signal_out), 32'h00);
    check_val("arst_f0_out",  32'(if_f0.signal_out),  32'h00);
    wait_cyc(2);
    sb.delete();
    rst_n = 1'b1;

    // No pulses after release while input holds the reset value.
    c = cyc;
    for (int j = 1; j <= 8; j++) push(D_RV, c + j, 8'hA5, 8'h00, 8'h00, "rv_quiet");
    wait_cyc(8);
    c = cyc;
    push(D_RV, c + 2, 8'hA5, 8'h00, 8'h00, "rv_pre");
    push(D_RV, c + 3, 8'hA4, 8'h00, 8'h01, "rv_fall");
    push(D_RV, c + 4, 8'hA4, 8'h00, 8'h00, "rv_post");
    if_rv.signal_in = 8'hA4;

    // Drain with a bounded wait.
    for (int j = 0; j < 40 && sb.size() != 0; j++) wait_cyc(1);
    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d still pending", sb[i].tag, sb[i].at);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
